uart_tx_fifo_drain: RTL

- UART transmitter that sits directly downstream of the async FIFO read side, in the read (TX) clock domain.
- Pops one word per frame through the FIFO's EMPTY / R_INC / RD_DATA interface.
- Serialises each word LSB-first with start bit, optional parity bit and stop bit.
- Sends one bit per CLK cycle; CLK is the already-divided baud clock.

---
 rtl/uart_tx_fifo_drain.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter that drains an async FIFO read port and sends one bit per baud CLK.
// Optional parity: define UART_TX_PARITY_EN to add the PAR_EN/PAR_TYP ports and the PARITY state.
module uart_tx_fifo_drain #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  FIFO_EMPTY,
   input  logic [DATA_WIDTH-1:0] FIFO_RD_DATA,
   output logic                  FIFO_RD_INC,
`ifdef UART_TX_PARITY_EN
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
`endif
   output logic                  TX_OUT,
   output logic                  BUSY
);

   localparam int               CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_e;

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [CNT_W-1:0]      cnt_q,   cnt_d;
   logic                  tx_q,    tx_d;
   logic                  busy_q,  busy_d;
   logic                  pop;
`ifdef UART_TX_PARITY_EN
   logic                  par_en_q,  par_en_d;
   logic                  par_bit_q, par_bit_d;
`endif

   // The pop strobe is combinational so the word is captured on the same edge that advances
   // the FIFO pointer; gating with RST keeps the FIFO untouched while held in reset.
   assign pop = RST && !FIFO_EMPTY && ((state_q == S_IDLE) || (state_q == S_STOP));

   always_comb begin
      // NOTE: every next-state value defaults to its current value first, so no path infers a latch.
      state_d   = state_q;
      shift_d   = shift_q;
      cnt_d     = cnt_q;
      tx_d      = tx_q;
      busy_d    = busy_q;
`ifdef UART_TX_PARITY_EN
      par_en_d  = par_en_q;
      par_bit_d = par_bit_q;
`endif

      unique case (state_q)
         S_IDLE: begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
         end
         S_START: begin
            state_d = S_DATA;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
            cnt_d   = '0;
         end
         S_DATA: begin
            if (cnt_q == CNT_LAST) begin
`ifdef UART_TX_PARITY_EN
               if (par_en_q) begin
                  state_d = S_PARITY;
                  tx_d    = par_bit_q;
               end else begin
                  state_d = S_STOP;
                  tx_d    = 1'b1;
               end
`else
               state_d = S_STOP;
               tx_d    = 1'b1;
`endif
            end else begin
               tx_d    = shift_q[0];
               shift_d = shift_q >> 1;
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            state_d = S_STOP;
            tx_d    = 1'b1;
         end
`endif
         S_STOP: begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
         end
      endcase

      // A pop (from IDLE or STOP) overrides the arm above and starts the next frame at once.
      if (pop) begin
         state_d   = S_START;
         shift_d   = FIFO_RD_DATA;
         cnt_d     = '0;
         tx_d      = 1'b0;
         busy_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
         par_en_d  = PAR_EN;
         par_bit_d = (^FIFO_RD_DATA) ^ PAR_TYP;
`endif
      end
   end

   // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q   <= S_IDLE;
         shift_q   <= '0;
         cnt_q     <= '0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         cnt_q     <= cnt_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
         par_en_q  <= par_en_d;
         par_bit_q <= par_bit_d;
`endif
      end
   end

   assign FIFO_RD_INC = pop;
   assign TX_OUT      = tx_q;
   assign BUSY        = busy_q;

endmodule
